// File: rtl/axi_mem_if.sv
// AXI4-Lite style read/write channel bundle (AR/R, AW/W/B) between the data-memory master and a memory responder.
interface axi_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_mem_slave.sv
// Single-outstanding AXI4-Lite memory responder with programmable read latency.
// Optional macro AXI_MEM_SLAVE_RANGE_CHECK_EN: out-of-window accesses get SLVERR instead of aliasing.
//
// state     | meaning
// S_IDLE    | accepts one request (write wins over read)
// S_RD_WAIT | counting read latency
// S_RD_RESP | rvalid high, waiting for rready
// S_WR_RESP | bvalid high, waiting for bready
module axi_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LAT     = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  axi_mem_if.slave  io_axi
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         NBYTES   = DATA_WIDTH / 8;
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RD_RESP = 2'd2,
    S_WR_RESP = 2'd3
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_rd_idx;
  logic                    r_rd_ok;
  logic [3:0]              r_lat_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_rvalid;
  logic [1:0]              r_bresp;
  logic                    r_bvalid;

  logic                    w_idle;
  logic                    w_wr_req;
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic [ADDR_WIDTH-1:0]   w_aw_off;
  logic [ADDR_WIDTH-1:0]   w_ar_off;
  logic [DEPTH_LOG2-1:0]   w_aw_idx;
  logic [DEPTH_LOG2-1:0]   w_ar_idx;
  logic                    w_aw_ok;
  logic                    w_ar_ok;
  logic                    w_unused;

  // Readies are gated by reset so nothing is accepted while rst is held low.
  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_req  = io_axi.awvalid & io_axi.wvalid;
  assign w_wr_fire = i_rst_n & w_idle & w_wr_req;
  assign w_rd_fire = i_rst_n & w_idle & io_axi.arvalid & ~w_wr_req;

  assign w_aw_off = io_axi.awaddr - BASE_ADDR;
  assign w_ar_off = io_axi.araddr - BASE_ADDR;
  assign w_aw_idx = w_aw_off[DEPTH_LOG2+2:3];
  assign w_ar_idx = w_ar_off[DEPTH_LOG2+2:3];

`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to huge offsets and fail the same test.
  assign w_aw_ok  = (w_aw_off >> (DEPTH_LOG2 + 3)) == '0;
  assign w_ar_ok  = (w_ar_off >> (DEPTH_LOG2 + 3)) == '0;
  assign w_unused = ^{w_aw_off[2:0], w_ar_off[2:0]};
`else
  assign w_aw_ok  = 1'b1;
  assign w_ar_ok  = 1'b1;
  assign w_unused = ^{w_aw_off[ADDR_WIDTH-1:DEPTH_LOG2+3], w_aw_off[2:0],
                      w_ar_off[ADDR_WIDTH-1:DEPTH_LOG2+3], w_ar_off[2:0]};
`endif

  assign io_axi.arready = w_rd_fire;
  assign io_axi.awready = w_wr_fire;
  assign io_axi.wready  = w_wr_fire;
  assign io_axi.rdata   = r_rdata;
  assign io_axi.rresp   = r_rresp;
  assign io_axi.rvalid  = r_rvalid;
  assign io_axi.bresp   = r_bresp;
  assign io_axi.bvalid  = r_bvalid;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire && w_aw_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (io_axi.wstrb[i]) begin
          r_mem[w_aw_idx][8*i +: 8] <= io_axi.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rd_idx  <= '0;
      r_rd_ok   <= 1'b0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OK;
      r_rvalid  <= 1'b0;
      r_bresp   <= RESP_OK;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_fire) begin
            r_state  <= S_WR_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_ok ? RESP_OK : RESP_ERR;
          end else if (w_rd_fire) begin
            r_rd_idx  <= w_ar_idx;
            r_rd_ok   <= w_ar_ok;
            r_lat_cnt <= LAT_INIT;
            if (RD_LAT == 1) begin
              r_state  <= S_RD_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= w_ar_ok ? r_mem[w_ar_idx] : '0;
              r_rresp  <= w_ar_ok ? RESP_OK : RESP_ERR;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            r_state  <= S_RD_RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= r_rd_ok ? r_mem[r_rd_idx] : '0;
            r_rresp  <= r_rd_ok ? RESP_OK : RESP_ERR;
          end
        end
        S_RD_RESP: begin
          if (io_axi.rready) begin
            r_state  <= S_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        S_WR_RESP: begin
          if (io_axi.bready) begin
            r_state  <= S_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed vector table, corner-case sequences, randomized traffic vs. a word-array model.
module tb_axi_mem_slave;
  localparam int          RD_LAT = 2;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h8000_0000;
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
  localparam bit          RC     = 1'b1;
`else
  localparam bit          RC     = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  vec_t        vecs[$];
  logic [63:0] ref_mem [int];
  logic [63:0] rd;
  logic [1:0]  rs;
  logic [63:0] exp_d;
  logic [1:0]  exp_r;
  logic [31:0] a;
  logic [63:0] d;
  logic [7:0]  s;
  bit          seen;

  axi_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH_LOG2(10),
    .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_axi  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off / 8) % DEPTH);
  endfunction

  function automatic bit ref_in(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return !RC || (off < 32'(8 * DEPTH));
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] w;
    int k;
    if (!ref_in(addr)) return;
    k = ref_idx(addr);
    w = ref_mem.exists(k) ? ref_mem[k] : 64'h0;
    for (int i = 0; i < 8; i++)
      if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
    ref_mem[k] = w;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int hold, output logic [1:0] resp);
    int t;
    int lat;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!(bus.awready && bus.wready) && t < 50) begin @(negedge clk); t++; end
    check("aw_w_accept", 64'({bus.awready, bus.wready}), 64'(2'b11));
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.bvalid && lat < 50);
    check("b_latency", 64'(lat), 64'(1));
    resp = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(bus.bvalid), 64'(1));
      check("bresp_hold", 64'(bus.bresp), 64'(resp));
    end
    @(posedge clk); #1;
    bus.bready = 1'b1;
    if (hold > 0) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [63:0] data, output logic [1:0] resp);
    int t;
    int lat;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < 50) begin @(negedge clk); t++; end
    check("ar_accept", 64'(bus.arready), 64'(1));
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rvalid && lat < 50);
    check("r_latency", 64'(lat), 64'(RD_LAT));
    data = bus.rdata;
    resp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", 64'(bus.rvalid), 64'(1));
      check("rdata_hold", bus.rdata, data);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    if (hold > 0) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;

    vecs.push_back('{1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0013, 64'h0123_4567_89AB_CDEF, 8'h81, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0017, 64'h0, 8'h00, 64'h01AD_BEEF_CAFE_F0EF, 2'b00});
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
    vecs.push_back('{1'b0, 32'h9000_0000, 64'h0, 8'h00, 64'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h8000_2008, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 2'b10});
    vecs.push_back('{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00});
`else
    vecs.push_back('{1'b0, 32'h8000_2008, 64'h0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00});
`endif

    // Reset state, with every valid asserted while reset is held.
    #12;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #6;
    check("rst_arready", 64'(bus.arready), 64'(0));
    check("rst_awready", 64'(bus.awready), 64'(0));
    check("rst_wready", 64'(bus.wready), 64'(0));
    check("rst_rvalid", 64'(bus.rvalid), 64'(0));
    check("rst_bvalid", 64'(bus.bvalid), 64'(0));
    check("rst_rdata", bus.rdata, 64'h0);
    check("rst_rresp", 64'(bus.rresp), 64'(0));
    check("rst_bresp", 64'(bus.bresp), 64'(0));
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, rs);
        check("vec_bresp", 64'(rs), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 0, rd, rs);
        check("vec_rdata", rd, vecs[i].exp_data);
        check("vec_rresp", 64'(rs), 64'(vecs[i].exp_resp));
      end
    end

    // Prefill the random working set so the model knows every word.
    for (int k = 0; k < 16; k++) begin
      d = {$urandom, $urandom};
      a = BASE + 32'(8 * k);
      do_write(a, d, 8'hFF, 0, rs);
      ref_write(a, d, 8'hFF);
    end

    // Simultaneous AR and AW/W: write wins, read waits for B plus an IDLE cycle.
    @(posedge clk); #1;
    bus.araddr = BASE + 32'h8; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h20; bus.wdata = 64'hFEED_FACE_0BAD_F00D; bus.wstrb = 8'hFF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    check("both_awready", 64'(bus.awready), 64'(1));
    check("both_wready", 64'(bus.wready), 64'(1));
    check("both_arready", 64'(bus.arready), 64'(0));
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    ref_write(BASE + 32'h20, 64'hFEED_FACE_0BAD_F00D, 8'hFF);
    @(negedge clk);
    check("both_bvalid", 64'(bus.bvalid), 64'(1));
    check("both_arready_busy", 64'(bus.arready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("both_bvalid_drop", 64'(bus.bvalid), 64'(0));
    check("both_arready_idle", 64'(bus.arready), 64'(1));
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    begin
      int lat;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rvalid && lat < 50);
      check("both_r_latency", 64'(lat), 64'(RD_LAT));
      check("both_rdata", bus.rdata, ref_mem[ref_idx(BASE + 32'h8)]);
    end
    @(posedge clk); #1;

    // Master stalls on both response channels.
    do_write(BASE + 32'h18, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 5, rs);
    ref_write(BASE + 32'h18, 64'h0F0E_0D0C_0B0A_0908, 8'hFF);
    check("stall_bresp", 64'(rs), 64'(0));
    do_read(BASE + 32'h18, 5, rd, rs);
    check("stall_rdata", rd, 64'h0F0E_0D0C_0B0A_0908);

    // Reset pulse while the read latency is counting.
    @(posedge clk); #1;
    bus.araddr = BASE + 32'h18; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    check("rstmid_arready", 64'(bus.arready), 64'(1));
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("rstmid_wait_rvalid", 64'(bus.rvalid), 64'(0));
    #2;
    rst_n = 1'b0;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.awaddr = BASE + 32'h18; bus.wdata = 64'h0; bus.wstrb = 8'hFF;
    #1;
    check("rstmid_arready", 64'(bus.arready), 64'(0));
    check("rstmid_awready", 64'(bus.awready), 64'(0));
    check("rstmid_wready", 64'(bus.wready), 64'(0));
    check("rstmid_rvalid", 64'(bus.rvalid), 64'(0));
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rvalid || bus.bvalid) seen = 1'b1;
    end
    check("rstmid_no_response", 64'(seen), 64'(0));
    do_read(BASE + 32'h18, 0, rd, rs);
    check("rstmid_next_read", rd, 64'h0F0E_0D0C_0B0A_0908);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      a = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a + 32'(8 * DEPTH * $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom_range(0, 255));
        exp_r = ref_in(a) ? 2'b00 : 2'b10;
        do_write(a, d, s, $urandom_range(0, 2), rs);
        ref_write(a, d, s);
        check("rand_bresp", 64'(rs), 64'(exp_r));
      end else begin
        exp_d = ref_in(a) ? ref_mem[ref_idx(a)] : 64'h0;
        exp_r = ref_in(a) ? 2'b00 : 2'b10;
        do_read(a, $urandom_range(0, 2), rd, rs);
        check("rand_rdata", rd, exp_d);
        check("rand_rresp", 64'(rs), 64'(exp_r));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4-Lite style memory responder: the slave end of the read/write channel set (AR/R, AW/W/B) that the data-memory access path drives as master.
- Backs a word-addressed on-chip storage array mapped at BASE_ADDR.
- Provides configurable read latency so master-side handshake and stall logic can be exercised against a real responder rather than DPI calls.
- One transaction in flight at a time.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 64, data bus width (8 byte lanes)
DEPTH_LOG2, 10, log2 of array depth in 64-bit words (default 8 KiB)
BASE_ADDR, 32'h80000000, first byte address served
RD_LAT, 2, cycles from AR handshake to rvalid rising; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  8  byte strobes; bit i enables byte i
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset (rst low, asynchronous): state IDLE; arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp = bresp = 2'b00; latency counter = 0. Array contents are not reset.
- Reset asserted mid-transaction abandons the transaction with no response. A write whose handshake already completed stays committed.
- Word index = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits. addr[2:0] is ignored; all accesses are 8-byte aligned words and wstrb selects the bytes.
- States:
  - IDLE: accepts one request.
  - RD_WAIT: counting read latency.
  - RD_RESP: rvalid high.
  - WR_RESP: bvalid high.
- IDLE ready signals (combinational from valids, state == IDLE only):
  - awready = wready = awvalid & wvalid. AW and W are accepted only together, in the same cycle.
  - arready = arvalid & !(awvalid & wvalid). Write wins when both are requested.
- Write handshake cycle:
  - Each byte lane with wstrb[i] = 1 is written at the clock edge.
  - Next state WR_RESP; bvalid = 1, bresp = 2'b00.
  - bvalid and bresp are held until bready. On bvalid & bready go to IDLE; bvalid drops on the following cycle.
- Read handshake cycle:
  - Latch the index. Counter = RD_LAT-1.
  - If RD_LAT == 1, go straight to RD_RESP. Otherwise go to RD_WAIT, which decrements each cycle and moves to RD_RESP when the counter reaches 1.
  - rdata and rresp are loaded from the array on entry to RD_RESP (rvalid rises exactly RD_LAT cycles after the AR handshake edge).
  - rdata and rresp are held stable while rvalid & !rready. On rvalid & rready go to IDLE.
- No ready is asserted outside IDLE. Back-to-back transactions have a minimum spacing of one IDLE cycle after a response handshake.
- Read-after-write: a read accepted after a write handshake returns the written bytes.
- Valids held by the master without ready are simply waited on; no timeout.

Optional Feature:
- Macro: AXI_MEM_SLAVE_RANGE_CHECK_EN.
- Defined:
  - Any address outside BASE_ADDR .. BASE_ADDR + 8*2^DEPTH_LOG2 - 1 returns response 2'b10 (SLVERR).
  - Out-of-range reads return rdata = 0.
  - Out-of-range writes leave the array unchanged.
  - Handshake timing is identical to in-range accesses.
- Undefined: no range check; the index is truncated (aliasing wrap-around); responses are always 2'b00.

Test Plan:
- Write 0x80000008, wdata 0x1122334455667788, wstrb 0xFF, then read 0x80000008 with RD_LAT = 2 -> bvalid one cycle after the AW/W handshake with bresp 00; rvalid exactly 2 cycles after the AR handshake with rdata 0x1122334455667788.
- Partial write wstrb 0x0F, wdata 0xAAAAAAAA_BBBBBBBB to the same word -> readback 0x11223344_BBBBBBBB.
- arvalid, awvalid and wvalid all asserted in one IDLE cycle -> awready = wready = 1, arready = 0. The read is accepted only after the B handshake completes plus one IDLE cycle.
- rready held low 5 cycles during RD_RESP -> rvalid and rdata stable all 5 cycles; bready similarly held low -> bvalid and bresp held.
- rst pulsed low during RD_WAIT -> rvalid = 0 and all readies = 0 immediately; state IDLE after rst rises; the next read completes normally.
- With AXI_MEM_SLAVE_RANGE_CHECK_EN, read 0x90000000 -> rresp 2'b10, rdata 0. Without the macro, reading 0x80002008 (DEPTH_LOG2 = 10) returns the word at 0x80000008.
